// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter sharing one non-pipelined AHB master port (single NONSEQ
// transfers) among NUM_REQ local requesters, with HREADY wait-state timeout.
module ahb_master_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*3-1:0]      req_size,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic                      err,
    output logic                      timeout,
    output logic [ADDR_W-1:0]         HADDR,
    output logic                      HWRITE,
    output logic [1:0]                HTRANS,
    output logic [2:0]                HSIZE,
    output logic [DATA_W-1:0]         HWDATA,
    input  logic                      HREADY,
    input  logic [DATA_W-1:0]         HRDATA,
    input  logic                      HRESP
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [CNT_W-1:0]   wait_cnt;
    logic               err_acc;
    logic [DATA_W-1:0]  wdata_lat;

    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   next_ptr;

    // First requesting index at or after the pointer, wrapping cyclically.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_valid && req[(int'(ptr) + k) % NUM_REQ]) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    assign next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    // NOTE: all state and outputs are updated with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            owner     <= '0;
            wait_cnt  <= '0;
            err_acc   <= 1'b0;
            wdata_lat <= '0;
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            timeout   <= 1'b0;
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HTRANS    <= TRANS_IDLE;
            HSIZE     <= '0;
            HWDATA    <= '0;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        owner     <= sel_idx;
                        gnt       <= NUM_REQ'(1) << sel_idx;
                        HTRANS    <= TRANS_NONSEQ;
                        HADDR     <= req_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
                        HWRITE    <= req_write[sel_idx];
                        HSIZE     <= req_size[int'(sel_idx)*3 +: 3];
                        wdata_lat <= req_wdata[int'(sel_idx)*DATA_W +: DATA_W];
                        err       <= 1'b0;
                        timeout   <= 1'b0;
                        state     <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (HREADY) begin
                        HTRANS   <= TRANS_IDLE;
                        HWDATA   <= HWRITE ? wdata_lat : '0;
                        wait_cnt <= '0;
                        err_acc  <= 1'b0;
                        state    <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    err_acc <= err_acc | HRESP;
                    if (HREADY) begin
                        rdata <= HWRITE ? '0 : HRDATA;
                        err   <= err_acc | HRESP;
                        done  <= gnt;
                        gnt   <= '0;
                        ptr   <= next_ptr;
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        // This low edge is the TIMEOUT-th one: abandon the transfer.
                        if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                            rdata   <= '0;
                            err     <= 1'b1;
                            timeout <= 1'b1;
                            done    <= gnt;
                            gnt     <= '0;
                            ptr     <= next_ptr;
                            state   <= ST_IDLE;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: a simple bridge model answers the bus,
// a scoreboard queue holds expected completions checked by a done monitor.
module tb_ahb_master_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic                      HCLK = 1'b0;
    logic                      HRESETn = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]        req_write = '0;
    logic [NUM_REQ*3-1:0]      req_size = '0;
    logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rdata;
    logic                      err;
    logic                      timeout;
    logic [ADDR_W-1:0]         HADDR;
    logic                      HWRITE;
    logic [1:0]                HTRANS;
    logic [2:0]                HSIZE;
    logic [DATA_W-1:0]         HWDATA;
    logic                      HREADY = 1'b1;
    logic [DATA_W-1:0]         HRDATA = '0;
    logic                      HRESP = 1'b0;

    ahb_master_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .req      (req),
        .req_addr (req_addr),
        .req_write(req_write),
        .req_size (req_size),
        .req_wdata(req_wdata),
        .gnt      (gnt),
        .done     (done),
        .rdata    (rdata),
        .err      (err),
        .timeout  (timeout),
        .HADDR    (HADDR),
        .HWRITE   (HWRITE),
        .HTRANS   (HTRANS),
        .HSIZE    (HSIZE),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HRDATA   (HRDATA),
        .HRESP    (HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bridge model: ws HREADY-low cycles per data phase, optional ERROR response.
    int          ws       = 0;
    logic        resp_err = 1'b0;
    logic [31:0] rd_value = '0;
    bit          in_data  = 1'b0;
    int          bcnt     = 0;

    always @(posedge HCLK) begin
        if (!HRESETn) begin
            in_data = 1'b0;
        end else if (in_data) begin
            if (HREADY) in_data = 1'b0;
            else        bcnt++;
        end else if (HTRANS == 2'b10 && HREADY) begin
            in_data = 1'b1;
            bcnt    = 0;
        end
    end

    always @(negedge HCLK) begin
        if (done != '0) in_data = 1'b0;
        HREADY = !(in_data && (bcnt < ws));
        HRESP  = in_data && resp_err;
        HRDATA = in_data ? rd_value : 32'hBAD0_BAD0;
    end

    // Completion monitor
    exp_t               mon_e;
    logic [NUM_REQ-1:0] mon_oh;

    always @(negedge HCLK) begin
        if (HRESETn && done != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                mon_e  = sb.pop_front();
                mon_oh = '0;
                mon_oh[mon_e.idx] = 1'b1;
                check("done_owner",   done,    mon_oh);
                check("done_cycle",   cyc,     mon_e.cyc);
                check("done_rdata",   rdata,   mon_e.rdata);
                check("done_err",     err,     mon_e.err);
                check("done_timeout", timeout, mon_e.tmo);
                check("gnt_cleared",  gnt,     0);
            end
        end
    end

    task automatic set_req(input int i, input logic [31:0] addr, input logic wr,
                           input logic [2:0] size, input logic [31:0] wd);
        req_addr[i*ADDR_W +: ADDR_W]  = addr;
        req_write[i]                  = wr;
        req_size[i*3 +: 3]            = size;
        req_wdata[i*DATA_W +: DATA_W] = wd;
    endtask

    task automatic expect_done(input int i, input logic [31:0] rd, input logic e,
                               input logic t, input int lat);
        exp_t x;
        x.idx   = i;
        x.rdata = rd;
        x.err   = e;
        x.tmo   = t;
        x.cyc   = cyc + lat;
        sb.push_back(x);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        do begin
            @(negedge HCLK);
            k++;
        end while (done == '0 && k < budget);
        check("done_within_budget", done != '0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge HCLK);
        check("reset_gnt",    gnt, 0);
        check("reset_htrans", HTRANS, 0);
        check("reset_bus",    {HADDR, HWDATA}, 0);
        check("reset_flags",  {done, err, timeout, HWRITE, HSIZE}, 0);
        check("reset_rdata",  rdata, 0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Single zero-wait write from requester 0
        set_req(0, 32'h8000_0010, 1'b1, 3'b010, 32'hDEAD_BEEF);
        ws = 0; resp_err = 1'b0;
        req[0] = 1'b1;
        expect_done(0, 32'h0, 1'b0, 1'b0, 3);
        @(negedge HCLK);
        check("t1_htrans_nonseq", HTRANS, 2'b10);
        check("t1_haddr",         HADDR, 32'h8000_0010);
        check("t1_hwrite",        HWRITE, 1);
        check("t1_hsize",         HSIZE, 3'b010);
        check("t1_gnt",           gnt, 2'b01);
        @(negedge HCLK);
        check("t1_htrans_idle",   HTRANS, 2'b00);
        check("t1_hwdata",        HWDATA, 32'hDEAD_BEEF);
        wait_done(4);
        req[0] = 1'b0;
        @(negedge HCLK);
        check("t1_after_idle",    HTRANS, 2'b00);

        // Read from requester 1 with two wait states
        set_req(1, 32'h8000_0004, 1'b0, 3'b010, 32'h0);
        ws = 2; rd_value = 32'h1234_5678;
        req[1] = 1'b1;
        expect_done(1, 32'h1234_5678, 1'b0, 1'b0, 5);
        @(negedge HCLK);
        check("t2_gnt",    gnt, 2'b10);
        check("t2_hwrite", HWRITE, 0);
        wait_done(8);
        req[1] = 1'b0;
        @(negedge HCLK);

        // Round robin with both requesters held high
        set_req(0, 32'h8000_0100, 1'b1, 3'b010, 32'hA5A5_0001);
        set_req(1, 32'h8000_0200, 1'b0, 3'b010, 32'h0);
        ws = 0; rd_value = 32'h5A5A_0002;
        req = 2'b11;
        expect_done(0, 32'h0,         1'b0, 1'b0, 3);
        expect_done(1, 32'h5A5A_0002, 1'b0, 1'b0, 6);
        expect_done(0, 32'h0,         1'b0, 1'b0, 9);
        expect_done(1, 32'h5A5A_0002, 1'b0, 1'b0, 12);
        for (int n = 0; n < 4; n++) wait_done(5);
        req = 2'b00;
        @(negedge HCLK);

        // Error response: ERROR with HREADY low, then ERROR with HREADY high
        set_req(0, 32'h8000_0020, 1'b0, 3'b000, 32'h0);
        ws = 1; resp_err = 1'b1; rd_value = 32'h0BAD_0001;
        req[0] = 1'b1;
        expect_done(0, 32'h0BAD_0001, 1'b1, 1'b0, 4);
        wait_done(6);
        req[0] = 1'b0;
        resp_err = 1'b0; ws = 0;
        @(negedge HCLK);
        check("t4_err_held", err, 1);

        set_req(1, 32'h8000_0024, 1'b1, 3'b010, 32'h0000_00FF);
        req[1] = 1'b1;
        expect_done(1, 32'h0, 1'b0, 1'b0, 3);
        @(negedge HCLK);
        check("t4_flags_cleared_on_grant", {err, timeout}, 0);
        check("t4_gnt", gnt, 2'b10);
        wait_done(4);
        req[1] = 1'b0;
        @(negedge HCLK);

        // Timeout: HREADY never returns in the data phase
        set_req(0, 32'h8000_0030, 1'b1, 3'b010, 32'h1111_2222);
        ws = 1000;
        req[0] = 1'b1;
        expect_done(0, 32'h0, 1'b1, 1'b1, 2 + TIMEOUT);
        wait_done(TIMEOUT + 8);
        req[0] = 1'b0;
        check("t5_htrans_idle", HTRANS, 2'b00);
        @(negedge HCLK);
        check("t5_still_idle", {HTRANS, gnt}, 0);

        // Reset while in the data phase
        set_req(0, 32'h8000_0040, 1'b1, 3'b010, 32'h3333_4444);
        req = 2'b01;
        repeat (3) @(negedge HCLK);
        check("t6_in_data", {HTRANS, gnt}, 4'b00_01);
        #2 HRESETn = 1'b0;
        #1;
        check("t6_rst_gnt_htrans", {HTRANS, gnt}, 0);
        check("t6_rst_haddr",      HADDR, 0);
        check("t6_rst_flags",      {done, err, timeout}, 0);
        req = 2'b10;
        set_req(1, 32'h8000_0004, 1'b0, 3'b010, 32'h0);
        ws = 0; rd_value = 32'hCAFE_F00D;
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        expect_done(1, 32'hCAFE_F00D, 1'b0, 1'b0, 3);
        @(negedge HCLK);
        check("t6_gnt_after_reset", gnt, 2'b10);
        check("t6_haddr",           HADDR, 32'h8000_0004);
        wait_done(4);
        req = 2'b00;
        repeat (3) @(negedge HCLK);

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
